mips_bus_ram_responder: RTL and testbench
=========================================

# mips_bus_ram_responder

Synthesizable memory responder for the `mips_cpu_bus` Avalon-style interface: decodes CPU bus requests, inserts wait states via `waitrequest`, performs byte-enabled writes and registered reads against an internal word array. It replaces the behavioural memory model in CPU benches and serves as the boot/data RAM in FPGA builds. Storage is big-endian (byte lane 0 ↔ storage bits [31:24]), matching the assembler's memory-image format.

## Interface
- `BASE_ADDR`, 32'hBFC00000, byte address mapped to word 0
- `DEPTH_WORDS`, 1024, number of 32-bit words
- `WAIT_CYCLES`, 1, wait cycles per transfer; legal range 1..15
- `INIT_FILE`, "", binary `$readmemb` image; empty means no preload

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `address`  in  32  byte address; bits [1:0] ignored
- `read`  in  1  read request, held by the master until accepted
- `write`  in  1  write request, held by the master until accepted
- `byteenable`  in  4  lane enables; bit n covers data bits [8n+7:8n]
- `writedata`  in  32  write data
- `waitrequest`  out  1  high = request not yet accepted
- `readdata`  out  32  registered read data
- `err`  out  1  one-cycle pulse on completion of an illegal or out-of-range access

## Operation
- Offset = `address` − `BASE_ADDR`. Index = offset >> 2.
- In range means `address` ≥ `BASE_ADDR` and offset < DEPTH_WORDS×4. Address 0 is out of range.
- FSM states:
  - IDLE: a request is `read` or `write` high. On a request, load the counter with WAIT_CYCLES−1 and go to WAIT.
  - WAIT: the counter decrements each cycle. At 0, go to ACK. On the edge that leaves WAIT, capture `readdata` for reads.
  - ACK: one cycle. The write commits on the edge that leaves ACK. Return to IDLE.
- `waitrequest` = (`read`|`write`) && state≠ACK. This is combinational from the request inputs, so it is 0 in IDLE when there is no request.
- Write: for each lane n with `byteenable`[n]=1, storage[index] bits [31−8n:24−8n] ← `writedata`[8n+7:8n]. Lanes with enable 0 are unchanged.
- Read: `readdata`[8n+7:8n] ← storage[index] bits [31−8n:24−8n] for each enabled lane. Disabled lanes return 8'h00.
- `readdata` holds its value until the next read completes. Writes do not change `readdata`.
- Out-of-range access: the write has no effect, the read returns 32'h0, and `err` pulses in the ACK cycle.
- `read` and `write` both high: treated as illegal. There is no memory effect, `readdata` ← 0, and `err` pulses in ACK.
- If the request drops while in WAIT (protocol violation), the responder still completes the transfer using the captured command.
- Address, command, byteenable and writedata are captured at acceptance in IDLE. Later changes to these inputs are ignored.

## Timing
- Reset values: state IDLE, counter 0, `readdata` 32'h0, `err` 0. `waitrequest` follows the request inputs.
- Memory contents are not cleared by reset.
- Reset asserted mid-transfer aborts the transfer: no write commits and `readdata` is not updated.
- Request first high in cycle T0:
  - `waitrequest` is 1 in cycles T0..T0+WAIT_CYCLES−1 and 0 in cycle T0+WAIT_CYCLES (ACK).
  - Read data is valid in `readdata` from cycle T0+WAIT_CYCLES.
  - A write is visible to a read accepted in cycle T0+WAIT_CYCLES+1.
- Back-to-back requests: if the request is still high in the cycle after ACK, a new transfer starts from IDLE. Minimum period is WAIT_CYCLES+1 cycles.

## Configuration
- `MIPS_BUS_RAM_RANDOM_STALL_EN` defined:
  - Adds an 8-bit Fibonacci LFSR with taps 8,6,5,4, seeded 8'hA5 at reset, which advances every cycle.
  - At acceptance, lfsr[1:0] (0..3) extra wait cycles are added to WAIT_CYCLES.
- Macro undefined: the wait is exactly WAIT_CYCLES and there is no LFSR logic.

## Structure
- Package `mips_bus_pkg` holds:
  - `BUS_BASE_ADDR` constant
  - `bus_state_t` enum (IDLE, WAIT, ACK)
  - function `lane_swap(word)` for the big-endian lane mapping
- One sub-module, `mips_bus_lfsr8`, instantiated only under the macro.
- Storage is an inferred single-port RAM with byte write enables.

## Test plan
- Preload word 0 = 32'h11223344. Read 32'hBFC00000 with be=4'hF → `waitrequest` high 1 cycle, then `readdata`=32'h44332211 and `err`=0.
- Write 32'hBFC00008 with be=4'b0001 and data 32'h000000AB, then read it with be=4'hF → storage word 2 bits [31:24]=8'hAB, other bytes unchanged.
- Read address 32'h0 → `readdata`=0 and `err` pulses for 1 cycle. Write 32'hBFC01000 (DEPTH_WORDS=1024) → no memory change and `err` pulses.
- With WAIT_CYCLES=3, hold `read` for two back-to-back transfers → `waitrequest` pattern 1,1,1,0,1,1,1,0.
- Assert `reset` in cycle T0+1 of a write with WAIT_CYCLES=3 → target word unchanged, `readdata`=0, FSM in IDLE.
- With `MIPS_BUS_RAM_RANDOM_STALL_EN` defined, run 100 reads → every wait length is in [WAIT_CYCLES, WAIT_CYCLES+3] and the data matches the preload.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus RAM responder.
// Storage is big-endian: bus lane 0 maps to storage bits [31:24].
package mips_bus_pkg;

   localparam logic [31:0] BUS_BASE_ADDR = 32'hBFC00000;
   localparam int          CNT_W         = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } bus_state_t;

   function automatic logic [31:0] lane_swap(input logic [31:0] word);
      return {word[7:0], word[15:8], word[23:16], word[31:24]};
   endfunction

   function automatic logic [3:0] be_swap(input logic [3:0] be);
      return {be[0], be[1], be[2], be[3]};
   endfunction

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/mips_bus_ram_responder_if.sv
// Avalon-style mips_cpu_bus signal bundle; the CPU (or bench) drives the
// master side, the RAM responder implements the slave side.
interface mips_bus_ram_responder_if;

   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        err;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, err
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, err
   );

endinterface

// File: rtl/mips_bus_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying 0..3 extra wait cycles.
// Only built when MIPS_BUS_RAM_RANDOM_STALL_EN is defined.
`ifdef MIPS_BUS_RAM_RANDOM_STALL_EN
module mips_bus_lfsr8 (
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] stall
);

   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = lfsr[1:0];

endmodule
`endif

// File: rtl/mips_bus_ram_responder.sv
// Wait-stated RAM slave for mips_cpu_bus with byte-enabled writes and registered reads.
// Define MIPS_BUS_RAM_RANDOM_STALL_EN to add 0..3 pseudo-random extra wait cycles.
module mips_bus_ram_responder
   import mips_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BUS_BASE_ADDR,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter              INIT_FILE   = ""
) (
   input logic                     clk,
   input logic                     reset,
   mips_bus_ram_responder_if.slave bus
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   bus_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_load;
   logic             req, accept, capture_rd, commit_wr;

   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] live_idx, cap_idx, ram_idx;

   logic             cap_rd_cmd, cap_rd_ok, cap_wr_ok, cap_bad;
   logic [3:0]       cap_be;
   logic [31:0]      cap_wdata;
   logic             rd_cmd, rd_ok;
   logic [3:0]       rd_be;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [31:0]      readdata_q;
   logic [31:0]      wr_word;
   logic [3:0]       wr_lanes;

   assign req      = bus.read | bus.write;
   assign offset   = bus.address - BASE_ADDR;
   assign in_range = (bus.address >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
   assign live_idx = offset[IDX_W+1:2];

`ifdef MIPS_BUS_RAM_RANDOM_STALL_EN
   logic [1:0] stall;

   mips_bus_lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .stall (stall)
   );

   assign cnt_load = CNT_W'(WAIT_CYCLES - 1) + CNT_W'(stall);
`else
   assign cnt_load = CNT_W'(WAIT_CYCLES - 1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The IDLE acceptance cycle is itself the first wait cycle, so a
   // one-cycle wait goes straight to ACK.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      capture_rd = 1'b0;
      commit_wr  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (cnt_load == '0) begin
                  state_next = ACK;
                  capture_rd = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = cnt_load;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               state_next = ACK;
               capture_rd = 1'b1;
            end
         end
         ACK: begin
            state_next = IDLE;
            cnt_next   = '0;
            commit_wr  = cap_wr_ok;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cap_idx    <= live_idx;
         cap_be     <= bus.byteenable;
         cap_wdata  <= bus.writedata;
         cap_rd_cmd <= bus.read;
         cap_rd_ok  <= bus.read & ~bus.write & in_range;
         cap_wr_ok  <= bus.write & ~bus.read & in_range;
         cap_bad    <= (bus.read & bus.write) | ~in_range;
      end
   end

   // In IDLE the read is served from the live request, afterwards from the capture.
   assign rd_cmd  = (state == IDLE) ? bus.read : cap_rd_cmd;
   assign rd_ok   = (state == IDLE) ? (bus.read & ~bus.write & in_range) : cap_rd_ok;
   assign rd_be   = (state == IDLE) ? bus.byteenable : cap_be;
   assign ram_idx = (state == IDLE) ? live_idx : cap_idx;

   assign wr_word  = lane_swap(cap_wdata);
   assign wr_lanes = be_swap(cap_be);

   always_ff @(posedge clk) begin
      if (commit_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_lanes[k]) mem[ram_idx][8*k +: 8] <= wr_word[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata_q <= '0;
      end else if (capture_rd && rd_cmd) begin
         readdata_q <= rd_ok ? (lane_swap(mem[ram_idx]) & be_mask(rd_be)) : '0;
      end
   end

   assign bus.waitrequest = req && (state != ACK);
   assign bus.readdata    = readdata_q;
   assign bus.err         = (state == ACK) && cap_bad;

endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// Randomized bench for mips_bus_ram_responder against a byte-addressed memory model;
// one DUT with a 1-cycle wait, one with a 3-cycle wait.
module tb_mips_bus_ram_responder;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        rd, wr;
   logic [31:0] addr, wd;
   logic [3:0]  be;
   logic        wreq_obs, err_obs;
   logic [31:0] rdata_obs;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mb [16][4];
   logic [31:0] last1;
   logic [31:0] oob_tab [4] = '{32'h0, 32'hBFC01000, 32'hBFBFFFFC, 32'hFFFFFFFC};

   always #5 clk = ~clk;

   mips_bus_ram_responder_if bus1 ();
   mips_bus_ram_responder_if bus3 ();

   assign bus1.address    = addr;
   assign bus1.read       = rd & ~sel;
   assign bus1.write      = wr & ~sel;
   assign bus1.byteenable = be;
   assign bus1.writedata  = wd;
   assign bus3.address    = addr;
   assign bus3.read       = rd & sel;
   assign bus3.write      = wr & sel;
   assign bus3.byteenable = be;
   assign bus3.writedata  = wd;

   assign wreq_obs  = sel ? bus3.waitrequest : bus1.waitrequest;
   assign err_obs   = sel ? bus3.err : bus1.err;
   assign rdata_obs = sel ? bus3.readdata : bus1.readdata;

   mips_bus_ram_responder #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   mips_bus_ram_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int s);
      return BASE + 32'((s == 15) ? 1023 * 4 : s * 4);
   endfunction

   // Byte at address 4*word+n travels on lane n.
   function automatic logic [31:0] model_read(input int s, input logic [3:0] b);
      logic [31:0] r;
      for (int n = 0; n < 4; n++) r[8*n +: 8] = b[n] ? mb[s][n] : 8'h00;
      return r;
   endfunction

   task automatic model_write(input int s, input logic [3:0] b, input logic [31:0] d);
      for (int n = 0; n < 4; n++) if (b[n]) mb[s][n] = d[8*n +: 8];
   endtask

   task automatic xfer(input logic s, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rdata, output logic e);
      int waits;
      int wexp;
      @(negedge clk);
      sel = s; addr = a; rd = r; wr = w; be = b; wd = d;
      waits = 0;
      wexp = s ? 3 : 1;
      #1;
      while (wreq_obs && waits < 64) begin
         waits++;
         @(negedge clk);
         #1;
      end
      chk("ack_seen", 32'(wreq_obs), 32'd0);
`ifdef MIPS_BUS_RAM_RANDOM_STALL_EN
      chk("wait_range", 32'(waits >= wexp && waits <= wexp + 3), 32'd1);
`else
      chk("wait_len", 32'(waits), 32'(wexp));
`endif
      rdata = rdata_obs;
      e = err_obs;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      #1;
      chk("err_clear", 32'(err_obs), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] got, d, a;
      logic        e, isrd, iswr, bad;
      logic [3:0]  b;
      int          op, s;

      reset = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0;
      last1 = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rdata1", bus1.readdata, 32'h0);
      chk("rst_rdata3", bus3.readdata, 32'h0);
      chk("rst_err", 32'(bus1.err | bus3.err), 32'd0);
      chk("rst_wreq", 32'(bus1.waitrequest | bus3.waitrequest), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 16; k++) begin
         d = (k == 0) ? 32'h44332211 : $urandom;
         xfer(1'b0, 1'b0, 1'b1, addr_of(k), 4'hF, d, got, e);
         model_write(k, 4'hF, d);
         chk("pre_err", 32'(e), 32'd0);
      end

      xfer(1'b0, 1'b1, 1'b0, BASE, 4'hF, 32'h0, got, e);
      last1 = 32'h44332211;
      chk("rd_word0", got, 32'h44332211);
      chk("rd_word0_err", 32'(e), 32'd0);

      xfer(1'b0, 1'b0, 1'b1, 32'hBFC00008, 4'b0001, 32'h000000AB, got, e);
      model_write(2, 4'b0001, 32'h000000AB);
      chk("wr_lane0_rdata_kept", got, last1);
      xfer(1'b0, 1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, got, e);
      last1 = model_read(2, 4'hF);
      chk("rd_word2", got, last1);
      chk("rd_word2_lane0", {24'h0, got[7:0]}, 32'h000000AB);

      xfer(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, got, e);
      last1 = 32'h0;
      chk("oob_rd_data", got, 32'h0);
      chk("oob_rd_err", 32'(e), 32'd1);
      xfer(1'b0, 1'b0, 1'b1, 32'hBFC01000, 4'hF, 32'hDEADBEEF, got, e);
      chk("oob_wr_err", 32'(e), 32'd1);
      xfer(1'b0, 1'b1, 1'b0, BASE, 4'hF, 32'h0, got, e);
      last1 = model_read(0, 4'hF);
      chk("oob_wr_no_alias", got, 32'h44332211);

      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 9);
         s  = $urandom_range(0, 15);
         b  = 4'($urandom_range(0, 15));
         d  = $urandom;
         a  = addr_of(s);
         isrd = (op <= 3) || op == 7 || op == 8;
         iswr = (op >= 4 && op <= 7) || op == 9;
         bad  = (op >= 7);
         if (op >= 8) a = oob_tab[$urandom_range(0, 3)];
         xfer(1'b0, isrd, iswr, a, b, d, got, e);
         if (isrd) last1 = bad ? 32'h0 : model_read(s, b);
         if (iswr && !bad) model_write(s, b, d);
         chk("rnd_rdata", got, last1);
         chk("rnd_err", 32'(e), 32'(bad));
      end

      xfer(1'b1, 1'b0, 1'b1, BASE + 32'd20, 4'hF, 32'hCAFEF00D, got, e);
      xfer(1'b1, 1'b1, 1'b0, BASE + 32'd20, 4'hF, 32'h0, got, e);
      chk("w3_rd", got, 32'hCAFEF00D);

`ifndef MIPS_BUS_RAM_RANDOM_STALL_EN
      begin
         logic [7:0] pat;
         pat = 8'b1110_1110;
         @(negedge clk);
         sel = 1'b1; addr = BASE + 32'd20; rd = 1'b1; wr = 1'b0; be = 4'hF;
         for (int k = 0; k < 8; k++) begin
            #1;
            chk("b2b_wreq", 32'(wreq_obs), 32'(pat[7-k]));
            @(negedge clk);
         end
         rd = 1'b0;
         #1;
         chk("b2b_rdata", rdata_obs, 32'hCAFEF00D);
      end
`endif

      @(negedge clk);
      sel = 1'b1; addr = BASE + 32'd20; rd = 1'b0; wr = 1'b1; be = 4'hF; wd = 32'h12345678;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_rdata", bus3.readdata, 32'h0);
      chk("abort_state", 32'(dut3.state), 32'(mips_bus_pkg::IDLE));
      @(negedge clk);
      wr = 1'b0;
      reset = 1'b0;
      last1 = 32'h0;
      #1;
      chk("abort_rdata1", bus1.readdata, last1);
      xfer(1'b1, 1'b1, 1'b0, BASE + 32'd20, 4'hF, 32'h0, got, e);
      chk("abort_no_commit", got, 32'hCAFEF00D);
      xfer(1'b0, 1'b1, 1'b0, addr_of(15), 4'hF, 32'h0, got, e);
      chk("mem_kept_reset", got, model_read(15, 4'hF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
